// File: rtl/shift_seq.sv
// Multi-cycle shift/rotate unit: latches one operand and applies power-of-two
// stages 8, 4, 2, 1 on successive clocks, then pulses done with the result.
module shift_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] in,
   input  logic [1:0]  op,
   input  logic [3:0]  cnt,
   output logic        ready,
   output logic        busy,
   output logic        done,
   output logic [15:0] out
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [15:0] data;
   logic [1:0]  op_r;
   logic [3:0]  cnt_r;
   logic [1:0]  idx;
   logic [15:0] stage_res;

   // One shifter cell of size 2^sel; all four ops share the same amount.
   function automatic logic [15:0] stage_fn(input logic [15:0] d,
                                            input logic [1:0]  o,
                                            input logic [1:0]  sel);
      logic [4:0]         k;
      logic signed [15:0] ds;
      k  = 5'd1 << sel;
      ds = d;
      case (o)
         2'b00:   stage_fn = (d << k) | (d >> (5'd16 - k));
         2'b01:   stage_fn = d << k;
         2'b10:   stage_fn = ds >>> k;
         default: stage_fn = d >> k;
      endcase
   endfunction

   always_comb begin
      stage_res = data;
      if (cnt_r[idx])
         stage_res = stage_fn(data, op_r, idx);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (start)
               state_nxt = SHIFT;
         end
         SHIFT: begin
            busy = 1'b1;
            if (idx == 2'd0)
               state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operand latch, per-stage working register and the held result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data  <= '0;
         op_r  <= '0;
         cnt_r <= '0;
         idx   <= '0;
         out   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  data  <= in;
                  op_r  <= op;
                  cnt_r <= cnt;
                  idx   <= 2'd3;
               end
            end
            SHIFT: begin
               data <= stage_res;
               idx  <= idx - 2'd1;
               if (idx == 2'd0)
                  out <= stage_res;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_shift_seq.sv
// Randomized self-checking bench for shift_seq against a whole-shift
// reference model, with cycle-accurate handshake checks.
module tb_shift_seq;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] in;
   logic [1:0]  op;
   logic [3:0]  cnt;
   logic        ready;
   logic        busy;
   logic        done;
   logic [15:0] out;

   int checks = 0;
   int errors = 0;
   logic [15:0] last_out;

   shift_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .in    (in),
      .op    (op),
      .cnt   (cnt),
      .ready (ready),
      .busy  (busy),
      .done  (done),
      .out   (out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] ref_shift(input logic [15:0] a, input logic [1:0] o,
                                             input logic [3:0] n);
      logic [31:0]        w;
      logic signed [15:0] sa;
      sa = a;
      case (o)
         2'b00: begin
            w = {a, a} << n;
            return w[31:16];
         end
         2'b01:   return a << n;
         2'b10:   return sa >>> n;
         default: return a >> n;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_ready"}, {15'd0, ready}, 16'd1);
      chk({tag, "_busy"},  {15'd0, busy},  16'd0);
      chk({tag, "_done"},  {15'd0, done},  16'd0);
      chk({tag, "_out"},   out,            last_out);
   endtask

   task automatic wait_ready();
      int n = 0;
      while (ready !== 1'b1 && n < 10) begin
         step();
         n++;
      end
      if (ready !== 1'b1) chk("wait_ready_timeout", {15'd0, ready}, 16'd1);
   endtask

   // Full transaction: start accepted at E0, busy E0..E3, done after E4, idle after E5.
   // During busy/done the inputs are scrambled and start is random; none of it may matter.
   task automatic do_op(input string tag, input logic [15:0] a, input logic [1:0] o,
                        input logic [3:0] n, input bit keep_start);
      logic [15:0] exp;
      exp = ref_shift(a, o, n);
      wait_ready();
      start = 1'b1; in = a; op = o; cnt = n;
      step();
      for (int i = 0; i < 4; i++) begin
         chk({tag, "_busy"},  {15'd0, busy},  16'd1);
         chk({tag, "_ready"}, {15'd0, ready}, 16'd0);
         chk({tag, "_done"},  {15'd0, done},  16'd0);
         chk({tag, "_hold"},  out,            last_out);
         start = $urandom_range(0, 1);
         in    = 16'($urandom);
         op    = 2'($urandom);
         cnt   = 4'($urandom);
         step();
      end
      chk({tag, "_donep"}, {15'd0, done}, 16'd1);
      chk({tag, "_nbusy"}, {15'd0, busy}, 16'd0);
      chk({tag, "_res"},   out,           exp);
      last_out = exp;
      start = keep_start;
      in    = 16'($urandom);
      step();
      check_idle({tag, "_after"});
      if (!keep_start) start = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; in = '0; op = '0; cnt = '0;
      last_out = 16'h0000;
      #12;
      check_idle("rst0");
      rst_n = 1'b1;
      step();
      check_idle("idle0");

      do_op("rol4",  16'h8421, 2'b00, 4'd4,  1'b0);
      do_op("sll1",  16'h8421, 2'b01, 4'd1,  1'b0);
      do_op("srl15", 16'h8000, 2'b11, 4'd15, 1'b0);
      do_op("sra15", 16'h8000, 2'b10, 4'd15, 1'b0);
      do_op("sra8",  16'h7F00, 2'b10, 4'd8,  1'b0);
      for (int o = 0; o < 4; o++)
         do_op("cnt0", 16'hBEEF, 2'(o), 4'd0, 1'b0);

      // Asynchronous reset mid-cycle while idle with a nonzero result held.
      #3;
      rst_n = 1'b0;
      #1;
      last_out = 16'h0000;
      check_idle("arst_idle");
      #2;
      rst_n = 1'b1;
      step();
      check_idle("arst_rel");

      // Back-to-back operations with start held high throughout.
      for (int i = 0; i < 6; i++)
         do_op("b2b", 16'($urandom), 2'($urandom), 4'($urandom), 1'b1);
      start = 1'b0;

      for (int i = 0; i < 40; i++)
         do_op("rnd", 16'($urandom), 2'($urandom), 4'($urandom), 1'b0);

      // Abort during SHIFT after E2: no done may follow.
      wait_ready();
      start = 1'b1; in = 16'h1234; op = 2'b01; cnt = 4'd3;
      step();
      start = 1'b0;
      step();
      step();
      #3;
      rst_n = 1'b0;
      #1;
      last_out = 16'h0000;
      check_idle("abort");
      step();
      check_idle("abort_hold");
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         check_idle("abort_nodone");
      end
      do_op("post", 16'h00FF, 2'b01, 4'd8, 1'b0);
      chk("post_ff00", out, 16'hFF00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
